// File: rtl/srisc_pkg.sv
// Shared SimpleRISC constants and types used by operand fetch, execute and
// the register write-back block.
package srisc_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 16;
    localparam int RA_IDX    = 15;
    localparam int REG_IDX_W = 4;
    localparam int LD_DEPTH  = 2;
    localparam int LD_CNT_W  = $clog2(LD_DEPTH + 1);

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [LD_CNT_W-1:0]  ld_cnt_t;

    // Return address is the call PC plus one instruction.
    localparam word_t PC_INC = word_t'(4);

    // The single register-array write port.
    typedef struct packed {
        logic     we;
        reg_idx_t addr;
        word_t    data;
    } wr_port_t;

endpackage

// File: rtl/register_writeback_if.sv
// Write-back request, load response and operand-fetch read bundle.
interface register_writeback_if;
    import srisc_pkg::*;

    logic     wb_valid;
    logic     wb_ready;
    reg_idx_t wb_rd;
    word_t    wb_data;
    logic     wb_isCall;
    word_t    wb_pc;
    logic     wb_isLd;

    logic     ld_valid;
    word_t    ld_data;

    reg_idx_t rd_addr1;
    reg_idx_t rd_addr2;
    word_t    rd_data1;
    word_t    rd_data2;
    logic     rd_busy1;
    logic     rd_busy2;

    ld_cnt_t  ld_pending;
    logic     err_unexp;

    // Execute / operand-fetch / memory side.
    modport master (
        output wb_valid, wb_rd, wb_data, wb_isCall, wb_pc, wb_isLd,
        output ld_valid, ld_data, rd_addr1, rd_addr2,
        input  wb_ready, rd_data1, rd_data2, rd_busy1, rd_busy2,
        input  ld_pending, err_unexp
    );

    // Register file write-back side.
    modport slave (
        input  wb_valid, wb_rd, wb_data, wb_isCall, wb_pc, wb_isLd,
        input  ld_valid, ld_data, rd_addr1, rd_addr2,
        output wb_ready, rd_data1, rd_data2, rd_busy1, rd_busy2,
        output ld_pending, err_unexp
    );

endinterface

// File: rtl/wb_load_fifo.sv
// In-order FIFO of destination register indices for outstanding loads.
module wb_load_fifo
    import srisc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  reg_idx_t i_push_idx,
    input  logic     i_pop,
    output reg_idx_t o_head,
    output ld_cnt_t  o_count,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    reg_idx_t r_mem [LD_DEPTH];
    ptr_t     r_wr_ptr;
    ptr_t     r_rd_ptr;
    ld_cnt_t  r_count;
    logic     w_push_ok;
    logic     w_pop_ok;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(LD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == ld_cnt_t'(LD_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Capture the destination index of a newly issued load.
    // NOTE: entry storage has no reset; r_count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_idx;
        end
    end

    // Advance pointers and occupancy count on push or pop.
    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/register_writeback.sv
// Register file write side: ALU/call writes, in-order load return,
// per-register load-pending flags and bypassed operand-fetch reads.
module register_writeback
    import srisc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    register_writeback_if.slave  bus
);

    word_t          r_regs [NREG];
    logic [NREG-1:0] r_pending;
    logic           r_err_unexp;

    reg_idx_t w_target;
    reg_idx_t w_head;
    ld_cnt_t  w_count;
    logic     w_full;
    logic     w_empty;
    logic     w_wb_ready;
    logic     w_wb_fire;
    logic     w_push;
    logic     w_pop;
    wr_port_t w_wr;

    // A call always targets the return-address register, whatever wb_rd says.
    assign w_target = bus.wb_isCall ? reg_idx_t'(RA_IDX) : bus.wb_rd;

    // Load responses own the write port; a full FIFO blocks new loads and a
    // pending target blocks any write to it (WAW behind a load).
    always_comb begin
        w_wb_ready = !bus.ld_valid
                     && !(bus.wb_isLd && w_full)
                     && !r_pending[w_target];
    end

    assign w_wb_fire = bus.wb_valid && w_wb_ready;
    assign w_push    = w_wb_fire && bus.wb_isLd && !bus.wb_isCall;
    assign w_pop     = bus.ld_valid && !w_empty;

    wb_load_fifo u_load_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_idx (bus.wb_rd),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Select the single array write for this cycle: load return first.
    // NOTE: every field gets a default before the branches so no latch is inferred.
    always_comb begin
        w_wr = '0;
        if (w_pop) begin
            w_wr.we   = 1'b1;
            w_wr.addr = w_head;
            w_wr.data = bus.ld_data;
        end else if (w_wb_fire && !bus.wb_isLd) begin
            w_wr.we   = 1'b1;
            w_wr.addr = w_target;
            w_wr.data = bus.wb_isCall ? (bus.wb_pc + PC_INC) : bus.wb_data;
        end
    end

    // Architectural register array; cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr.we) begin
            r_regs[w_wr.addr] <= w_wr.data;
        end
    end

    // Pending flags: set on load issue, cleared when its response returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (w_pop) begin
                r_pending[w_head] <= 1'b0;
            end
            if (w_push) begin
                r_pending[bus.wb_rd] <= 1'b1;
            end
        end
    end

    // Sticky flag for a load response with nothing outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_unexp <= 1'b0;
        end else if (bus.ld_valid && w_empty) begin
            r_err_unexp <= 1'b1;
        end
    end

    // Read ports see the committed array plus this cycle's write.
    always_comb begin
        bus.rd_data1 = (w_wr.we && (w_wr.addr == bus.rd_addr1)) ? w_wr.data : r_regs[bus.rd_addr1];
        bus.rd_data2 = (w_wr.we && (w_wr.addr == bus.rd_addr2)) ? w_wr.data : r_regs[bus.rd_addr2];
        bus.rd_busy1 = r_pending[bus.rd_addr1] && !(w_pop && (w_head == bus.rd_addr1));
        bus.rd_busy2 = r_pending[bus.rd_addr2] && !(w_pop && (w_head == bus.rd_addr2));
    end

    assign bus.wb_ready   = w_wb_ready;
    assign bus.ld_pending = w_count;
    assign bus.err_unexp  = r_err_unexp;

endmodule

// File: tb/tb_register_writeback.sv
// Directed self-checking bench for register_writeback.
module tb_register_writeback;
    import srisc_pkg::*;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    register_writeback_if u_if ();

    register_writeback u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        u_if.wb_valid  = 1'b0;
        u_if.wb_rd     = '0;
        u_if.wb_data   = '0;
        u_if.wb_isCall = 1'b0;
        u_if.wb_pc     = '0;
        u_if.wb_isLd   = 1'b0;
        u_if.ld_valid  = 1'b0;
        u_if.ld_data   = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_idle();
        u_if.rd_addr1 = '0;
        u_if.rd_addr2 = '0;
        #3;
        for (int i = 0; i < NREG; i++) begin
            u_if.rd_addr1 = reg_idx_t'(i);
            u_if.rd_addr2 = reg_idx_t'(NREG - 1 - i);
            #1;
            if (u_if.rd_data1 !== 32'h0) begin n_bad++; $display("FAIL rst_rd1[%0d]: got %h want 00000000", i, u_if.rd_data1); end
            n_total++;
            if (u_if.rd_data2 !== 32'h0) begin n_bad++; $display("FAIL rst_rd2[%0d]: got %h want 00000000", i, u_if.rd_data2); end
            n_total++;
            if (u_if.rd_busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy[%0d]: got %b want 0", i, u_if.rd_busy1); end
            n_total++;
        end
        if (u_if.ld_pending !== 2'd0) begin n_bad++; $display("FAIL rst_ld_pending: got %0d want 0", u_if.ld_pending); end
        n_total++;
        if (u_if.err_unexp !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", u_if.err_unexp); end
        n_total++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_bypass;
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 4'd3;
        u_if.wb_data  = 32'hDEADBEEF;
        u_if.rd_addr1 = 4'd3;
        #1;
        if (u_if.wb_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %b want 1", u_if.wb_ready); end
        n_total++;
        if (u_if.rd_data1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_bypass: got %h want deadbeef", u_if.rd_data1); end
        n_total++;
        tick();
        drive_idle();
        #1;
        if (u_if.rd_data1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_commit: got %h want deadbeef", u_if.rd_data1); end
        n_total++;
    endtask

    task automatic test_call_wrap;
        // Seed r2 and r15 with non-zero values so the wrap and the ignored wb_rd are visible.
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 4'd2;
        u_if.wb_data  = 32'h12345678;
        tick();
        u_if.wb_rd    = 4'd15;
        u_if.wb_data  = 32'h00000055;
        tick();
        u_if.wb_isCall = 1'b1;
        u_if.wb_pc     = 32'hFFFFFFFC;
        u_if.wb_rd     = 4'd2;
        u_if.wb_data   = 32'hAAAAAAAA;
        u_if.rd_addr1  = 4'd15;
        u_if.rd_addr2  = 4'd2;
        #1;
        if (u_if.wb_ready !== 1'b1) begin n_bad++; $display("FAIL call_ready: got %b want 1", u_if.wb_ready); end
        n_total++;
        if (u_if.rd_data1 !== 32'h0) begin n_bad++; $display("FAIL call_bypass: got %h want 00000000", u_if.rd_data1); end
        n_total++;
        tick();
        drive_idle();
        #1;
        if (u_if.rd_data1 !== 32'h0) begin n_bad++; $display("FAIL call_r15: got %h want 00000000", u_if.rd_data1); end
        n_total++;
        if (u_if.rd_data2 !== 32'h12345678) begin n_bad++; $display("FAIL call_r2: got %h want 12345678", u_if.rd_data2); end
        n_total++;
    endtask

    task automatic test_loads;
        u_if.wb_valid = 1'b1;
        u_if.wb_isLd  = 1'b1;
        u_if.wb_rd    = 4'd4;
        #1;
        if (u_if.wb_ready !== 1'b1) begin n_bad++; $display("FAIL ld1_ready: got %b want 1", u_if.wb_ready); end
        n_total++;
        tick();
        u_if.wb_rd = 4'd5;
        #1;
        if (u_if.ld_pending !== 2'd1) begin n_bad++; $display("FAIL ld1_count: got %0d want 1", u_if.ld_pending); end
        n_total++;
        tick();
        drive_idle();
        u_if.rd_addr1 = 4'd4;
        u_if.rd_addr2 = 4'd5;
        #1;
        if (u_if.ld_pending !== 2'd2) begin n_bad++; $display("FAIL ld2_count: got %0d want 2", u_if.ld_pending); end
        n_total++;
        if ({u_if.rd_busy1, u_if.rd_busy2} !== 2'b11) begin n_bad++; $display("FAIL ld2_busy: got %b want 11", {u_if.rd_busy1, u_if.rd_busy2}); end
        n_total++;
        // Third load with the FIFO full must stall.
        u_if.wb_valid = 1'b1;
        u_if.wb_isLd  = 1'b1;
        u_if.wb_rd    = 4'd7;
        #1;
        if (u_if.wb_ready !== 1'b0) begin n_bad++; $display("FAIL ld3_stall: got %b want 0", u_if.wb_ready); end
        n_total++;
        tick();
        drive_idle();
        #1;
        if (u_if.ld_pending !== 2'd2) begin n_bad++; $display("FAIL ld3_count: got %0d want 2", u_if.ld_pending); end
        n_total++;
        // First response returns to r4.
        u_if.ld_valid = 1'b1;
        u_if.ld_data  = 32'h11;
        #1;
        if (u_if.wb_ready !== 1'b0) begin n_bad++; $display("FAIL resp1_ready: got %b want 0", u_if.wb_ready); end
        n_total++;
        if (u_if.rd_data1 !== 32'h11) begin n_bad++; $display("FAIL resp1_bypass: got %h want 00000011", u_if.rd_data1); end
        n_total++;
        if ({u_if.rd_busy1, u_if.rd_busy2} !== 2'b01) begin n_bad++; $display("FAIL resp1_busy: got %b want 01", {u_if.rd_busy1, u_if.rd_busy2}); end
        n_total++;
        tick();
        u_if.ld_data = 32'h22;
        #1;
        if (u_if.ld_pending !== 2'd1) begin n_bad++; $display("FAIL resp1_count: got %0d want 1", u_if.ld_pending); end
        n_total++;
        if (u_if.rd_data1 !== 32'h11) begin n_bad++; $display("FAIL resp1_r4: got %h want 00000011", u_if.rd_data1); end
        n_total++;
        if (u_if.rd_data2 !== 32'h22) begin n_bad++; $display("FAIL resp2_bypass: got %h want 00000022", u_if.rd_data2); end
        n_total++;
        tick();
        drive_idle();
        #1;
        if (u_if.ld_pending !== 2'd0) begin n_bad++; $display("FAIL resp2_count: got %0d want 0", u_if.ld_pending); end
        n_total++;
        if (u_if.rd_data2 !== 32'h22) begin n_bad++; $display("FAIL resp2_r5: got %h want 00000022", u_if.rd_data2); end
        n_total++;
        if ({u_if.rd_busy1, u_if.rd_busy2} !== 2'b00) begin n_bad++; $display("FAIL resp2_busy: got %b want 00", {u_if.rd_busy1, u_if.rd_busy2}); end
        n_total++;
    endtask

    task automatic test_waw_stall;
        u_if.wb_valid = 1'b1;
        u_if.wb_isLd  = 1'b1;
        u_if.wb_rd    = 4'd6;
        tick();
        u_if.wb_isLd  = 1'b0;
        u_if.wb_data  = 32'h7;
        u_if.rd_addr1 = 4'd6;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (u_if.wb_ready !== 1'b0) begin n_bad++; $display("FAIL waw_stall[%0d]: got %b want 0", c, u_if.wb_ready); end
            n_total++;
            if (u_if.rd_busy1 !== 1'b1) begin n_bad++; $display("FAIL waw_busy[%0d]: got %b want 1", c, u_if.rd_busy1); end
            n_total++;
            tick();
        end
        u_if.ld_valid = 1'b1;
        u_if.ld_data  = 32'h99;
        #1;
        if (u_if.wb_ready !== 1'b0) begin n_bad++; $display("FAIL waw_resp_ready: got %b want 0", u_if.wb_ready); end
        n_total++;
        if (u_if.rd_data1 !== 32'h99) begin n_bad++; $display("FAIL waw_resp_bypass: got %h want 00000099", u_if.rd_data1); end
        n_total++;
        tick();
        u_if.ld_valid = 1'b0;
        #1;
        if (u_if.wb_ready !== 1'b1) begin n_bad++; $display("FAIL waw_release: got %b want 1", u_if.wb_ready); end
        n_total++;
        if (u_if.rd_data1 !== 32'h7) begin n_bad++; $display("FAIL waw_alu_bypass: got %h want 00000007", u_if.rd_data1); end
        n_total++;
        tick();
        drive_idle();
        #1;
        if (u_if.rd_data1 !== 32'h7) begin n_bad++; $display("FAIL waw_final: got %h want 00000007", u_if.rd_data1); end
        n_total++;
    endtask

    task automatic test_unexpected;
        u_if.ld_valid = 1'b1;
        u_if.ld_data  = 32'h00000BAD;
        u_if.rd_addr1 = 4'd3;
        u_if.rd_addr2 = 4'd4;
        #1;
        if (u_if.rd_data1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL unexp_nobypass: got %h want deadbeef", u_if.rd_data1); end
        n_total++;
        tick();
        u_if.ld_valid = 1'b0;
        #1;
        if (u_if.err_unexp !== 1'b1) begin n_bad++; $display("FAIL unexp_err: got %b want 1", u_if.err_unexp); end
        n_total++;
        if (u_if.rd_data1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL unexp_r3: got %h want deadbeef", u_if.rd_data1); end
        n_total++;
        if (u_if.rd_data2 !== 32'h11) begin n_bad++; $display("FAIL unexp_r4: got %h want 00000011", u_if.rd_data2); end
        n_total++;
        if (u_if.ld_pending !== 2'd0) begin n_bad++; $display("FAIL unexp_count: got %0d want 0", u_if.ld_pending); end
        n_total++;
        tick();
        tick();
        if (u_if.err_unexp !== 1'b1) begin n_bad++; $display("FAIL unexp_sticky: got %b want 1", u_if.err_unexp); end
        n_total++;
        // Leave a load outstanding, then reset asynchronously mid-cycle.
        u_if.wb_valid = 1'b1;
        u_if.wb_isLd  = 1'b1;
        u_if.wb_rd    = 4'd8;
        tick();
        drive_idle();
        u_if.rd_addr1 = 4'd8;
        #1;
        if (u_if.rd_busy1 !== 1'b1) begin n_bad++; $display("FAIL prerst_busy: got %b want 1", u_if.rd_busy1); end
        n_total++;
        #1;
        rst = 1'b1;
        #1;
        if (u_if.err_unexp !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %b want 0", u_if.err_unexp); end
        n_total++;
        if (u_if.ld_pending !== 2'd0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", u_if.ld_pending); end
        n_total++;
        if (u_if.rd_busy1 !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", u_if.rd_busy1); end
        n_total++;
        if (u_if.rd_data2 !== 32'h0) begin n_bad++; $display("FAIL arst_r4: got %h want 00000000", u_if.rd_data2); end
        n_total++;
        rst = 1'b0;
        tick();
        // The discarded load's response now arrives with nothing outstanding.
        u_if.ld_valid = 1'b1;
        u_if.ld_data  = 32'h5A5A5A5A;
        tick();
        u_if.ld_valid = 1'b0;
        #1;
        if (u_if.err_unexp !== 1'b1) begin n_bad++; $display("FAIL post_rst_resp_err: got %b want 1", u_if.err_unexp); end
        n_total++;
        if (u_if.rd_data1 !== 32'h0) begin n_bad++; $display("FAIL post_rst_r8: got %h want 00000000", u_if.rd_data1); end
        n_total++;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_write_bypass();
        test_call_wrap();
        test_loads();
        test_waw_stall();
        test_unexpected();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/register_writeback.md
# register_writeback

Write side of the SimpleRISC register file: accepts result writes from execute, tracks in-flight loads, and returns load data to its destination register in order. It also serves the two operand-fetch read ports with write-to-read bypass and per-register busy flags. It owns the 16 x 32 register storage, so operand fetch sees committed state plus the write committing this cycle.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 16, number of architectural registers
- RA_IDX, 15, return-address register written by call
- LD_DEPTH, 2, maximum outstanding loads

Ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  write request valid
- wb_ready  out  1  write request accepted when wb_valid && wb_ready
- wb_rd  in  4  destination register
- wb_data  in  XLEN  ALU/mov result
- wb_isCall  in  1  write wb_pc+4 to RA_IDX; ignore wb_rd and wb_data
- wb_pc  in  XLEN  PC of the call instruction
- wb_isLd  in  1  load issued; record wb_rd, no write now
- ld_valid  in  1  load response valid; always accepted
- ld_data  in  XLEN  load response data, in issue order
- rd_addr1, rd_addr2  in  4  operand-fetch read addresses
- rd_data1, rd_data2  out  XLEN  read data
- rd_busy1, rd_busy2  out  1  addressed register has a pending load
- ld_pending  out  2  outstanding load count, 0..LD_DEPTH
- err_unexp  out  1  sticky: ld_valid arrived with no load outstanding

## Operation
- At most one register-array write per cycle.
- Load responses have priority. While ld_valid=1, wb_ready=0.
- wb_ready = !ld_valid && !(wb_isLd && ld_pending==LD_DEPTH) && !pending[target], where target = RA_IDX if wb_isCall, else wb_rd. The pending check stalls write-after-write hazards behind a load.
- Accepted write with neither wb_isCall nor wb_isLd: reg[wb_rd] <= wb_data.
- Accepted call: reg[RA_IDX] <= wb_pc + 4, mod 2^XLEN with wrap.
- Accepted load: push wb_rd into the FIFO and set pending[wb_rd]. There is no array write.
- Load issued to a register that is already pending: stalled by the same rule, so each register has at most one load in flight.
- ld_valid with the FIFO non-empty: pop the head index h, reg[h] <= ld_data, clear pending[h].
- ld_valid with the FIFO empty: no write, err_unexp <= 1.
- Push and pop never happen in the same cycle, because wb_ready=0 whenever ld_valid=1.
- Reads are combinational. If a write to the same address commits this cycle, rd_data returns the write value; otherwise it returns the array value.
- rd_busy = pending[addr]. A bypassed load response shows busy=0 in the same cycle.
- r0 is an ordinary writable register.

## Timing
- Reset (asynchronous): all registers = 0, FIFO empty, pending = 0, ld_pending = 0, err_unexp = 0.
- Reset mid-operation discards outstanding loads. A response arriving after reset sets err_unexp.
- Write latency: the array updates on the clock edge after acceptance. It is visible on read ports in the same cycle through bypass.
- Load issue to data visible: set by the memory. The bypass covers the response cycle.
- wb_ready is combinational from ld_valid, wb_isLd, wb_isCall, wb_rd and state. Request inputs must be held stable while wb_valid=1 and wb_ready=0.
- ld_pending updates on the edge after a push or pop.
- err_unexp clears only on reset.

## Structure
- Shared package `srisc_pkg`: XLEN, NREG, RA_IDX, REG_IDX_W=4, and constant PC_INC=4. Operand fetch and execute use the same package.
- One sub-module, `wb_load_fifo`: a LD_DEPTH-entry FIFO of 4-bit register indices with push, pop, head, count and full/empty. Read/write pointers wrap modulo LD_DEPTH.
- The pending bit vector, register array, bypass and ready logic live in the top level.

## Test plan
- Reset, then read r0..r15 → all 0x00000000, busy=0, ld_pending=0, err_unexp=0.
- Write r3=0xDEADBEEF with rd_addr1=3 in the same cycle → rd_data1=0xDEADBEEF immediately (bypass) and after the edge.
- Call with wb_pc=0xFFFFFFFC, wb_rd=2 → r15=0x00000000 (wrap), r2 unchanged.
- Load r4, then load r5 → ld_pending=2, busy on r4 and r5. A third load is stalled. ld_valid 0x11 then 0x22 → r4=0x11, r5=0x22, pending cleared in order.
- Load r6 pending, then ALU write r6=0x7 → wb_ready=0 until the response 0x99 lands. The ALU write then commits: final r6=0x7.
- ld_valid=1 with no load outstanding → no register changes, err_unexp=1 and sticky. An asynchronous rst clears it.
